// File: rtl/result_packer.sv
// rtl/result_packer.sv - packs conv_pool byte results into 128-bit masked lines
// and queues them for the result memory behind a small FIFO.
module result_packer #(
  parameter int ADDR_W     = 16,
  parameter int TOTAL      = 65025,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_we,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [7:0]        in_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-5:0] out_addr,
  output logic [127:0]      out_data,
  output logic [15:0]       out_mask,
  output logic              frame_done,
  output logic              overflow,
  output logic              addr_err
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int IDX_W = ADDR_W - 4;
  localparam logic [ADDR_W:0]   TOTAL_W   = (ADDR_W+1)'(TOTAL);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);
  localparam logic [PTR_W:0]    DEPTH_W   = (PTR_W+1)'(FIFO_DEPTH);

  // LAST holds a final line opened by a line change; it is pushed the next cycle
  // because the FIFO takes only one line per edge.
  typedef enum logic [1:0] {IDLE, FILL, LAST, DONE} state_t;
  state_t state;

  logic [IDX_W-1:0] line_idx;
  logic [127:0]     line_data;
  logic [15:0]      line_mask;

  logic [IDX_W-1:0] fifo_idx  [FIFO_DEPTH];
  logic [127:0]     fifo_data [FIFO_DEPTH];
  logic [15:0]      fifo_mask [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0]   count;

  logic             accept, same_line, is_last, complete;
  logic [IDX_W-1:0] byte_idx;
  logic [3:0]       byte_off;
  logic [127:0]     merged_data;
  logic [15:0]      merged_mask;
  logic             push, push_ok, pop, full;
  logic [IDX_W-1:0] push_idx;
  logic [127:0]     push_data;
  logic [15:0]      push_mask;

  assign byte_idx  = in_addr[ADDR_W-1:4];
  assign byte_off  = in_addr[3:0];
  assign accept    = in_we && ({1'b0, in_addr} < TOTAL_W) && (state == IDLE || state == FILL);
  assign same_line = (state == FILL) && (byte_idx == line_idx);
  assign is_last   = (in_addr == LAST_ADDR);

  always_comb begin
    merged_data = same_line ? line_data : '0;
    merged_mask = same_line ? line_mask : '0;
    merged_data[{byte_off, 3'b000} +: 8] = in_y;
    merged_mask[byte_off] = 1'b1;
  end

  assign complete = (merged_mask == 16'hFFFF) || is_last;

  always_comb begin
    push      = 1'b0;
    push_idx  = line_idx;
    push_data = line_data;
    push_mask = line_mask;
    if (state == LAST) begin
      push = 1'b1;
    end else if (accept) begin
      if (state == FILL && !same_line) begin
        push = 1'b1;
      end else if (complete) begin
        push      = 1'b1;
        push_idx  = byte_idx;
        push_data = merged_data;
        push_mask = merged_mask;
      end
    end
  end

  assign out_valid = (count != '0);
  assign full      = (count == DEPTH_W);
  assign pop       = out_valid && out_ready;
  assign push_ok   = push && (!full || pop);

  assign out_addr = out_valid ? fifo_idx[rd_ptr]  : '0;
  assign out_data = out_valid ? fifo_data[rd_ptr] : '0;
  assign out_mask = out_valid ? fifo_mask[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_idx[wr_ptr]  <= push_idx;
      fifo_data[wr_ptr] <= push_data;
      fifo_mask[wr_ptr] <= push_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      line_idx   <= '0;
      line_data  <= '0;
      line_mask  <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      if (in_we && !accept) addr_err <= 1'b1;
      if (push && !push_ok) overflow <= 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push_ok, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: ;
      endcase
      if (state == DONE && count == '0) frame_done <= 1'b1;

      case (state)
        LAST: begin
          state     <= DONE;
          line_idx  <= '0;
          line_data <= '0;
          line_mask <= '0;
        end
        IDLE, FILL: begin
          if (accept) begin
            if (complete && (state == IDLE || same_line)) begin
              state     <= is_last ? DONE : IDLE;
              line_idx  <= '0;
              line_data <= '0;
              line_mask <= '0;
            end else begin
              state     <= is_last ? LAST : FILL;
              line_idx  <= byte_idx;
              line_data <= merged_data;
              line_mask <= merged_mask;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/result_packer.md
# result_packer

Downstream writeback stage for `conv_pool`. Consumes the byte-wide result stream (`output_we` / `output_addr` / `y`). Packs 16 consecutive 8-bit results into one 128-bit line with a byte mask, and hands lines to the result memory over a valid/ready port through a small FIFO. `conv_pool` cannot be stalled, so the FIFO absorbs memory backpressure; loss is flagged, never silent.

## Interface
Parameters:
- `ADDR_W`, 16, result byte address width (matches `conv_pool` `output_addr`).
- `TOTAL`, 65025, results per frame; last valid byte address is `TOTAL-1`.
- `FIFO_DEPTH`, 4, line buffer entries (power of two, ≥2).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_we`  in  1  result strobe (connects to `conv_pool.output_we`).
- `in_addr`  in  ADDR_W  result byte address (connects to `output_addr`).
- `in_y`  in  8  result byte (connects to `y`).
- `out_valid`  out  1  FIFO head holds a line.
- `out_ready`  in  1  memory accepts the head line this cycle.
- `out_addr`  out  ADDR_W-4  line index = byte address >> 4.
- `out_data`  out  128  byte i at bits [8i+7:8i].
- `out_mask`  out  16  byte enables; bit i set if byte i was written.
- `frame_done`  out  1  level; last line has left the FIFO.
- `overflow`  out  1  sticky; a line was dropped because the FIFO was full.
- `addr_err`  out  1  sticky; `in_we` arrived with `in_addr ≥ TOTAL`.

## Operation
- Line register: `line_idx`, `line_data[127:0]`, `line_mask[15:0]`.
- States:
  - IDLE: no line is open.
  - FILL: a line is open.
  - DONE: the last line has been flushed; the block waits for the FIFO to drain.
- Accepted byte: `in_we=1` and `in_addr < TOTAL`.
  - Out-of-range strobe: ignored, sets `addr_err`, no state change.
- IDLE, accepted byte: open a line at `in_addr>>4`, write the byte at `in_addr[3:0]`, set its mask bit, go to FILL.
- FILL, accepted byte on the same line: write the byte and set its mask bit. A repeated offset overwrites the byte (last write wins) with no error.
- FILL, accepted byte on a different line: push the current partial line, then open a new line holding this byte. Both happen at the same edge.
- Flush-complete: merged mask = 0xFFFF, or the byte is at `TOTAL-1`.
  - The line is pushed with this byte already merged, at the same edge.
  - Next state is IDLE, or DONE if the byte was at `TOTAL-1`.
- DONE: further strobes are ignored and set `addr_err`. `frame_done` sets once the FIFO is empty, and holds until `rst`.
- Push rules:
  - Push succeeds if the FIFO is not full, or if a pop happens in the same cycle.
  - Otherwise the pushed line is discarded and `overflow` sets. The line register still advances as normal.
- Pop: `out_valid & out_ready`. Output signals are driven from the FIFO head. Order is strictly FIFO.

## Timing
- Reset values (cycle after `rst` sampled high): `out_valid=0`, `out_addr=0`, `out_data=0`, `out_mask=0`, `frame_done=0`, `overflow=0`, `addr_err=0`, state IDLE, FIFO empty, line register cleared.
- Reset mid-operation discards the open line and all FIFO contents. No partial flush occurs.
- Latency: the byte sampled at edge k that completes a push gives `out_valid=1` after edge k, provided the FIFO was empty.
- Throughput: one `in_we` per cycle, one pop per cycle.
  - The worst case is a line change on every strobe: 1 push/cycle. This is sustainable when `out_ready=1`.
- Push and pop in the same cycle with the FIFO full: both occur, occupancy unchanged, no overflow.
- `out_valid` must not drop while `out_ready=0`. `out_addr`, `out_data` and `out_mask` are stable while stalled.
- `frame_done` rises on the edge after the last line is popped.

## Test plan
- Reset: hold `rst` 2 cycles with random inputs → every output 0; `out_valid` stays 0 for 5 idle cycles.
- Full line: `out_ready=1`; `in_we` addr 0..15 with `y=addr` on consecutive cycles → one beat the cycle after addr 15: `out_addr=0`, `out_data=0x0F0E0D0C0B0A09080706050403020100`, `out_mask=0xFFFF`.
- Partial line: addr 32..35 (y=0xA0..0xA3), then addr 48 → beat `out_addr=2`, `out_mask=0x000F`, `out_data[31:0]=0xA3A2A1A0`. Line 3 stays open with `mask=0x0001`.
- Backpressure: `out_ready=0`, 5 full lines (addr 0..79) → `overflow=1`, 4 lines buffered. Raise `out_ready` → beats for `out_addr` 0,1,2,3 in order, then `out_valid=0`.
- Frame end: addr 65008..65024 → beat `out_addr=4063` mask 0xFFFF, then beat `out_addr=4064` mask 0x0001. `frame_done=1` after the second pop. A later strobe sets `addr_err=1`.
- Reset mid-fill: addr 0..7 written, `rst` pulsed, then addr 16..31 → single beat `out_addr=1`; no beat for line 0.
